// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: latency-driven operand bypass select and issue stall over a DEPTH-entry shift scoreboard
module fwd_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 2,
    parameter int DEPTH          = 3,
    parameter int LAT_WIDTH      = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int SEL_W          = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              hold,
    input  logic                              flush,
    input  logic                              iss_valid,
    input  logic                              iss_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]         iss_rd,
    input  logic [LAT_WIDTH-1:0]              iss_lat,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_rs,
    input  logic [NUM_SRC-1:0]                src_used,
    output logic [NUM_SRC*SEL_W-1:0]          fwd_sel,
    output logic                              stall,
    output logic [CNT_WIDTH-1:0]              stall_cnt
);
    logic [DEPTH-1:0]                     vld_q;
    logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_q;
    logic [DEPTH-1:0][LAT_WIDTH-1:0]      cnt_q;
    logic [NUM_SRC-1:0]                   blocked;
    logic [NUM_SRC*SEL_W-1:0]             sel;
    logic [LAT_WIDTH-1:0]                 lat_clamp;
    logic                                 alloc;

    always_comb begin
        sel = '0;
        blocked = '0;
        for (int j = 0; j < NUM_SRC; j++)
            for (int i = DEPTH - 1; i >= 0; i--)
                if (src_used[j] && src_rs[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0 && vld_q[i] &&
                    rd_q[i] == src_rs[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) begin
                    sel[j*SEL_W +: SEL_W] = cnt_q[i] == '0 ? SEL_W'(i + 1) : '0;
                    blocked[j] = cnt_q[i] != '0;
                end
    end

    assign fwd_sel   = rst_n ? sel : '0;
    assign stall     = rst_n & iss_valid & (|blocked) & ~flush;
    assign lat_clamp = 32'(iss_lat) > DEPTH - 1 ? LAT_WIDTH'(DEPTH - 1) : iss_lat;
    assign alloc     = iss_valid & iss_wr_en & (iss_rd != '0) & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                rd_q[i] <= rd_q[i-1];
                cnt_q[i] <= cnt_q[i-1] == '0 ? '0 : cnt_q[i-1] - 1'b1;
            end
            vld_q[0] <= alloc;
            rd_q[0] <= alloc ? iss_rd : '0;
            cnt_q[0] <= alloc ? lat_clamp : '0;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vector table, counter saturation sequence and random run against a history model
module tb_fwd_scoreboard;
    localparam int DEPTH = 3;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst_n, hold, flush, iss_valid, iss_wr_en;
    logic [4:0] iss_rd;
    logic [1:0] iss_lat;
    logic [9:0] src_rs;
    logic [1:0] src_used;
    logic [3:0] fwd_sel;
    logic       stall;
    logic [7:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit r, h, f, v, we;
        int rd, lat, rs0, rs1, u;
        int s0, s1, st, c;
    } vec_t;
    vec_t tbl[$];

    // history model: slot k holds the write issued k+1 advancing edges ago
    bit m_v[DEPTH];
    int m_rd[DEPTH];
    int m_lat[DEPTH];
    int m_cnt;
    int e_sel[2];
    bit e_st;

    fwd_scoreboard #(.REG_ADDR_WIDTH(5), .NUM_SRC(2), .DEPTH(DEPTH), .LAT_WIDTH(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .iss_valid(iss_valid),
        .iss_wr_en(iss_wr_en), .iss_rd(iss_rd), .iss_lat(iss_lat), .src_rs(src_rs),
        .src_used(src_used), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit h, bit f, bit v, bit we, int rd, int lat, int rs0, int rs1,
                                int u, int s0, int s1, int st, int c);
        vec_t x;
        x.r = r; x.h = h; x.f = f; x.v = v; x.we = we; x.rd = rd; x.lat = lat;
        x.rs0 = rs0; x.rs1 = rs1; x.u = u; x.s0 = s0; x.s1 = s1; x.st = st; x.c = c;
        return x;
    endfunction

    task automatic drive(bit r, bit h, bit f, bit v, bit we, int rd, int lat, int rs0, int rs1, int u);
        rst_n = r; hold = h; flush = f; iss_valid = v; iss_wr_en = we;
        iss_rd = 5'(rd); iss_lat = 2'(lat); src_rs = {5'(rs1), 5'(rs0)}; src_used = 2'(u);
    endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_eval();
        bit blk = 0;
        for (int j = 0; j < 2; j++) begin
            int rs = j == 0 ? int'(src_rs[4:0]) : int'(src_rs[9:5]);
            e_sel[j] = 0;
            if (src_used[j] && rs != 0)
                for (int k = 0; k < DEPTH; k++)
                    if (m_v[k] && m_rd[k] == rs) begin
                        if (k >= (m_lat[k] < DEPTH - 1 ? m_lat[k] : DEPTH - 1)) e_sel[j] = k + 1;
                        else blk = 1;
                        break;
                    end
            if (!rst_n) e_sel[j] = 0;
        end
        e_st = rst_n && iss_valid && blk && !flush;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin m_v[k] = 0; m_rd[k] = 0; m_lat[k] = 0; end
            m_cnt = 0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_lat[k] = m_lat[k-1];
            end
            m_v[0] = iss_valid && iss_wr_en && iss_rd != 0 && !e_st && !flush;
            m_rd[0] = int'(iss_rd);
            m_lat[0] = int'(iss_lat);
            if (e_st && m_cnt < CMAX) m_cnt++;
        end
    endtask

    initial begin
        //            r h f v we rd lat rs0 rs1 u   s0 s1 st c
        tbl.push_back(mk(0,0,0,1,1, 5,0,  5, 0,1,  0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1, 5,0,  0, 0,0,  0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1, 6,0,  5, 0,1,  1,0,0,0));
        tbl.push_back(mk(1,0,0,1,0, 0,0,  0, 5,2,  0,2,0,0));
        tbl.push_back(mk(1,0,0,1,1, 7,1,  0, 0,0,  0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1, 8,0,  0, 7,2,  0,0,1,0));
        tbl.push_back(mk(1,0,0,1,1, 8,0,  0, 7,2,  0,2,0,1));
        tbl.push_back(mk(1,0,0,1,1, 3,0,  0, 0,0,  0,0,0,1));
        tbl.push_back(mk(1,0,0,1,1, 9,0,  0, 0,0,  0,0,0,1));
        tbl.push_back(mk(1,0,0,1,1, 3,0,  3, 0,1,  2,0,0,1));
        tbl.push_back(mk(1,0,0,1,0, 0,0,  3, 3,3,  1,1,0,1));
        tbl.push_back(mk(1,0,0,1,1, 3,0,  0, 0,0,  0,0,0,1));
        tbl.push_back(mk(1,0,0,1,1,10,0,  0, 0,0,  0,0,0,1));
        tbl.push_back(mk(1,0,0,1,1, 3,1,  0, 0,0,  0,0,0,1));
        tbl.push_back(mk(1,0,0,1,0, 0,0,  3, 0,1,  0,0,1,1));
        tbl.push_back(mk(1,0,0,1,0, 0,0,  3, 0,1,  2,0,0,2));
        tbl.push_back(mk(1,0,0,1,1, 0,0,  0, 3,1,  0,0,0,2));
        tbl.push_back(mk(1,0,0,1,1, 3,1,  0, 0,3,  0,0,0,2));
        tbl.push_back(mk(1,0,0,1,0, 0,0,  3, 0,2,  0,0,0,2));
        tbl.push_back(mk(1,0,0,1,1,11,2,  0, 0,0,  0,0,0,2));
        tbl.push_back(mk(1,1,0,1,0, 0,0, 11, 0,1,  0,0,1,2));
        tbl.push_back(mk(1,1,0,1,0, 0,0, 11, 0,1,  0,0,1,2));
        tbl.push_back(mk(1,1,0,1,0, 0,0, 11, 0,1,  0,0,1,2));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 11, 0,1,  0,0,1,2));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 11, 0,1,  0,0,1,3));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 11, 0,1,  3,0,0,4));
        tbl.push_back(mk(1,0,0,1,1,12,2,  0, 0,0,  0,0,0,4));
        tbl.push_back(mk(1,0,1,1,1,13,0, 12, 0,1,  0,0,0,4));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 12, 0,1,  0,0,1,4));
        tbl.push_back(mk(1,0,0,1,1,14,3,  0, 0,0,  0,0,0,5));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 14, 0,1,  0,0,1,5));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 14, 0,1,  0,0,1,6));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 14, 0,1,  3,0,0,7));
        tbl.push_back(mk(1,0,0,1,1,15,2,  0, 0,0,  0,0,0,7));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 15, 0,1,  0,0,1,7));
        tbl.push_back(mk(0,0,0,1,0, 0,0, 15, 0,1,  0,0,0,8));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 15, 0,1,  0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,15,1,  0, 0,0,  0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0, 15, 0,1,  0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0, 0,0, 15, 0,1,  2,0,0,0));

        drive(0,0,0,0,0,0,0,0,0,0);
        tick();
        tick();
        foreach (tbl[n]) begin
            drive(tbl[n].r, tbl[n].h, tbl[n].f, tbl[n].v, tbl[n].we, tbl[n].rd, tbl[n].lat,
                  tbl[n].rs0, tbl[n].rs1, tbl[n].u);
            #1;
            chk($sformatf("vec%0d sel0", n), 32'(fwd_sel[1:0]), tbl[n].s0);
            chk($sformatf("vec%0d sel1", n), 32'(fwd_sel[3:2]), tbl[n].s1);
            chk($sformatf("vec%0d stall", n), 32'(stall), tbl[n].st);
            chk($sformatf("vec%0d stall_cnt", n), 32'(stall_cnt), tbl[n].c);
            tick();
        end

        for (int it = 1; it <= 130; it++) begin
            drive(1,0,0,1,1,1,2,0,0,0);
            tick();
            drive(1,0,0,1,0,0,0,1,0,1);
            tick();
            tick();
            if (it == 100) chk("sat mid stall_cnt", 32'(stall_cnt), 200);
        end
        drive(1,0,0,0,0,0,0,0,0,0);
        #1;
        chk("sat stall_cnt", 32'(stall_cnt), CMAX);

        drive(0,0,0,0,0,0,0,0,0,0);
        model_eval();
        tick();
        model_update();
        for (int c = 0; c < 2000; c++) begin
            drive(($urandom % 64) != 0, ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                  ($urandom % 4) != 0, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4);
            #1;
            model_eval();
            chk($sformatf("rnd%0d sel0", c), 32'(fwd_sel[1:0]), e_sel[0]);
            chk($sformatf("rnd%0d sel1", c), 32'(fwd_sel[3:2]), e_sel[1]);
            chk($sformatf("rnd%0d stall", c), 32'(stall), 32'(e_st));
            chk($sformatf("rnd%0d stall_cnt", c), 32'(stall_cnt), m_cnt);
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
